// File: rtl/config_stream_ctrl.sv
// Wishbone-fed configuration streamer: buffers 32-bit words in a small FIFO and
// shifts them MSB-first onto per-column chains, then pulses set_out on commit.
module config_stream_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          NUM_COLS   = 4,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_data_i,
  input  logic [31:0]         wbs_addr_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_data_o,
  output logic                cen,
  output logic [NUM_COLS-1:0] shift_out,
  output logic [NUM_COLS-1:0] set_out,
  output logic                busy
);

  localparam int B  = 32 / NUM_COLS;
  localparam int KW = $clog2(B);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, SET} state_t;

  state_t          state, state_next;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     shreg;
  logic [KW-1:0]   k;
  logic [31:0]     words;
  logic            commit_pending, sel_err;
  logic [31:0]     rdata_p1;

  logic            decode, req, fifo_full, is_data, is_ctrl, accept;
  logic            push, pop, flush, commit_wr, sel_bad, sel_clr, last_bit;
  logic [7:0]      count8;
  logic [31:0]     rd_val;
  logic            unused_addr;

  assign unused_addr = ^{wbs_addr_i[23:4], wbs_addr_i[1:0]};

  assign decode    = (wbs_addr_i[31:24] == BASE_ADDR[31:24]);
  assign req       = wbs_stb_i & wbs_cyc_i & decode & ~wbs_ack_o;
  assign is_data   = (wbs_addr_i[3:2] == 2'd0);
  assign is_ctrl   = (wbs_addr_i[3:2] == 2'd1);
  assign fifo_full = (count == CW'(FIFO_DEPTH));
  // A DATA write into a full FIFO is held off (no ack) until the shifter pops.
  assign accept    = req & ~(wbs_we_i & is_data & fifo_full);

  assign push      = accept & wbs_we_i & is_data & (wbs_sel_i == 4'hF);
  assign sel_bad   = accept & wbs_we_i & is_data & (wbs_sel_i != 4'hF);
  assign flush     = accept & wbs_we_i & is_ctrl & wbs_data_i[1];
  assign commit_wr = accept & wbs_we_i & is_ctrl & wbs_data_i[0] & ~wbs_data_i[1];
  assign sel_clr   = accept & wbs_we_i & is_ctrl & wbs_data_i[2];

  assign last_bit  = (state == SHIFT) && (k == KW'(B - 1));
  assign pop       = ((state == IDLE) || last_bit) && (count != '0);

  assign busy      = (state != IDLE) || (count != '0) || commit_pending;
  assign count8    = 8'(count);

  always_comb begin
    rd_val = '0;
    case (wbs_addr_i[3:2])
      2'd2:    rd_val = {21'd0, sel_err, commit_pending, busy, count8};
      2'd3:    rd_val = words;
      default: rd_val = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (count != '0)         state_next = SHIFT;
        else if (commit_pending) state_next = SET;
      end
      SHIFT:   if (last_bit && (count == '0)) state_next = IDLE;
      SET:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_comb begin
    logic [4:0] idx;
    idx       = '0;
    cen       = 1'b0;
    shift_out = '0;
    set_out   = '0;
    case (state)
      SHIFT: begin
        cen = 1'b1;
        for (int c = 0; c < NUM_COLS; c++) begin
          idx          = 5'(c * B + B - 1) - 5'(k);
          shift_out[c] = shreg[idx];
        end
      end
      SET: begin
        cen     = 1'b1;
        set_out = '1;
      end
      default: ;
    endcase
  end

  // Bus response, FIFO pointers and counters
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o      <= 1'b0;
      rdata_p1       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      k              <= '0;
      words          <= '0;
      commit_pending <= 1'b0;
      sel_err        <= 1'b0;
    end else begin
      wbs_ack_o <= accept;
      rdata_p1  <= (accept & ~wbs_we_i) ? rd_val : 32'd0;

      if (sel_clr)      sel_err <= 1'b0;
      else if (sel_bad) sel_err <= 1'b1;

      if (flush) begin
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        count          <= '0;
        k              <= '0;
        words          <= '0;
        commit_pending <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase

        if (pop || last_bit)     k <= '0;
        else if (state == SHIFT) k <= k + KW'(1);

        if (last_bit) words <= words + 32'd1;

        // A commit arriving in the SET cycle itself survives for a later frame.
        if (commit_wr)           commit_pending <= 1'b1;
        else if (state == SET)   commit_pending <= 1'b0;
      end
    end
  end

  // Word storage and shift register carry no reset; their use is gated by control
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= wbs_data_i;
    if (pop)  shreg <= mem[rd_ptr];
  end

  assign wbs_data_o = wbs_ack_o ? rdata_p1 : 32'd0;

endmodule

// File: tb/tb_config_stream_ctrl.sv
// Directed bench for config_stream_ctrl: a scoreboard queue holds the expected
// shift_out vector for every cen cycle; a negedge monitor pops and compares.
module tb_config_stream_ctrl;

  localparam logic [31:0] A_DATA  = 32'h3000_0000;
  localparam logic [31:0] A_CTRL  = 32'h3000_0004;
  localparam logic [31:0] A_STAT  = 32'h3000_0008;
  localparam logic [31:0] A_WORDS = 32'h3000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] wdat = '0, adr = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        cen, busy;
  logic [3:0]  shift_out, set_out;

  int pass_cnt = 0, fail_cnt = 0, chk_cnt = 0;
  int set_cnt = 0, run = 0, last_run = 0;
  logic [3:0] exp_q[$];

  config_stream_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_data_i(wdat), .wbs_addr_i(adr),
    .wbs_ack_o(ack), .wbs_data_o(rdat),
    .cen(cen), .shift_out(shift_out), .set_out(set_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Column c of cycle k carries bit c*8+7-k of the word (MSB-first per byte)
  task automatic push_word(input logic [31:0] w);
    logic [3:0] v;
    for (int kk = 0; kk < 8; kk++) begin
      for (int c = 0; c < 4; c++) v[c] = w[c*8 + 7 - kk];
      exp_q.push_back(v);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int limit, output int lat, output bit acked);
    if (ack) tick();
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    acked = 1'b0; lat = 0;
    while (!acked && lat < limit) begin
      tick();
      lat++;
      if (ack) acked = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    if (ack) tick();
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a;
    d = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack) begin d = rdat; break; end
    end
    stb = 1'b0; cyc = 1'b0;
    check(tag, d, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cen && set_out == 4'h0) begin
        check("sb_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_shift_out", 32'(shift_out), 32'(exp_q.pop_front()));
        run <= run + 1;
      end else begin
        if (run > 0) last_run <= run;
        run <= 0;
      end
      if (set_out != 4'h0) begin
        check("set_vec", {27'd0, cen, set_out}, {27'd0, 1'b1, 4'hF});
        check("set_shift_zero", 32'(shift_out), 32'd0);
        set_cnt <= set_cnt + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, last_shift, set_i, exp_sets;
    bit a;
    int lats[7];
    logic [31:0] w;
    exp_sets = 0;

    // Reset and idle
    tick(); tick();
    check("rst_outs", {26'd0, ack, cen, busy, |shift_out, |set_out, |rdat},
          32'd0);
    rst = 1'b0;
    rd_check("rst_status", A_STAT, 32'h0);
    rd_check("rd_ctrl_zero", A_CTRL, 32'h0);
    check("data_o_gated", rdat, 32'h0);

    // Single word, then commit
    push_word(32'hA5C3_0FF0);
    wb_write(A_DATA, 32'hA5C3_0FF0, 4'hF, 20, lat, a);
    check("w1_lat", lat, 1);
    check("w1_cen_t1", 32'(cen), 0);
    tick();
    check("w1_cen_t2", 32'(cen), 1);
    wb_write(A_CTRL, 32'h1, 4'hF, 20, lat, a);
    check("commit_ack", 32'(a), 1);
    last_shift = -1; set_i = -10;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cen && set_out == 4'h0) last_shift = i;
      if (set_out != 4'h0) begin set_i = i; break; end
    end
    exp_sets++;
    check("set_gap", set_i, last_shift + 2);
    tick();
    check("set_one_cycle", 32'(set_out), 0);
    rd_check("w1_words", A_WORDS, 32'd1);

    // Commit on an idle, empty block
    wb_write(A_CTRL, 32'h1, 4'hF, 20, lat, a);
    check("idle_commit_t1", 32'(set_out), 0);
    tick();
    check("idle_commit_t2", 32'(set_out), 32'hF);
    exp_sets++;
    tick(); tick();

    // Backpressure: first six fit (one pop frees space), seventh stalls
    for (int i = 0; i < 7; i++) begin
      w = $urandom();
      push_word(w);
      wb_write(A_DATA, w, 4'hF, 50, lats[i], a);
    end
    for (int i = 0; i < 6; i++) check("bp_lat", lats[i], 1);
    check("bp_stall", 32'(lats[6] > 1), 1);
    rd_check("bp_status_full", A_STAT, 32'h0000_0104);
    for (int i = 0; i < 300 && busy; i++) tick();
    check("bp_drained", 32'(busy), 0);
    tick();
    check("bp_cen_run", last_run, 56);
    check("bp_sb_empty", exp_q.size(), 0);
    rd_check("bp_words", A_WORDS, 32'd8);

    // Flush mid-stream with commit in the same write
    for (int i = 0; i < 3; i++) begin
      w = 32'h0F1E_2D3C + 32'(i);
      push_word(w);
      wb_write(A_DATA, w, 4'hF, 20, lat, a);
      check("fl_lat", lat, 1);
    end
    wb_write(A_CTRL, 32'h3, 4'hF, 20, lat, a);
    check("fl_cen_drop", 32'(cen), 0);
    check("fl_shifted5", exp_q.size(), 19);
    exp_q.delete();
    for (int i = 0; i < 10; i++) tick();
    check("fl_no_set", set_cnt, exp_sets);
    rd_check("fl_status", A_STAT, 32'h0);
    rd_check("fl_words", A_WORDS, 32'h0);

    // Partial byte-select on DATA
    wb_write(A_DATA, 32'h1234_5678, 4'h3, 20, lat, a);
    check("sel_lat", lat, 1);
    rd_check("sel_status", A_STAT, 32'h0000_0400);
    wb_write(A_CTRL, 32'h4, 4'hF, 20, lat, a);
    rd_check("sel_cleared", A_STAT, 32'h0);

    // Out-of-region write
    wb_write(32'h3100_0000, 32'h1, 4'hF, 8, lat, a);
    check("decode_no_ack", 32'(a), 0);
    rd_check("decode_status", A_STAT, 32'h0);

    // Reset in the middle of a shift with a commit pending
    push_word(32'hFFFF_FFFF);
    wb_write(A_DATA, 32'hFFFF_FFFF, 4'hF, 20, lat, a);
    wb_write(A_CTRL, 32'h1, 4'hF, 20, lat, a);
    tick(); tick(); tick();
    check("pre_rst_cen", 32'(cen), 1);
    rst = 1'b1;
    tick();
    check("rst_mid_outs", {27'd0, cen, busy, |shift_out, |set_out, ack}, 32'd0);
    exp_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("rst_no_set", set_cnt, exp_sets);
    rd_check("rst_status2", A_STAT, 32'h0);
    rd_check("rst_words", A_WORDS, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
